// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time (in ck cycles) of an asynchronous PWM input.
// Latency: valid rises SYNC_STAGES+2 cycles after the pwm_in rise is first sampled (+FILT_LEN-1 with filter).
// Backpressure: none; each result is strobed once on valid and held until the next result.
// Optional glitch filter on the synchronized input: define PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int CNT_W       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEAS_HI = 2'd1,
    MEAS_LO = 2'd2
  } state_t;

  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_param
    $error("pwm_capture: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   lvl;
  logic                   lvl_q;
  logic                   rise_q;
  logic                   fall_q;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   pend_q, pend_d;
  logic                   valid_q;
  logic                   timeout_q, timeout_d;
  logic                   stuck_q, stuck_d;

  // Metastability chain: pwm_in is fully asynchronous to ck.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FC_W = $clog2(FILT_LEN + 1);

  logic            filt_q;
  logic [FC_W-1:0] fcnt_q, fcnt_d;

  // Accept a new level on the FILT_LEN-th consecutive sample that differs from the current one.
  always_comb begin
    lvl    = filt_q;
    fcnt_d = '0;
    if (s != filt_q) begin
      if (fcnt_q == FC_W'(FILT_LEN - 1)) begin
        lvl = s;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Filter state: accepted level and run length of differing samples.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= lvl;
      fcnt_q <= fcnt_d;
    end
  end
`else
  assign lvl = s;
`endif

  // Registered edge detect; lvl_q equals the new level in the cycle rise_q/fall_q is high.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      lvl_q  <= lvl;
      rise_q <= lvl & ~lvl_q;
      fall_q <= ~lvl & lvl_q;
    end
  end

  // Next-state logic: measurement FSM, saturating counter, result and timeout updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_lat_d  = hi_lat_q;
    period_d  = period_q;
    high_d    = high_q;
    pend_d    = 1'b0;
    timeout_d = timeout_q;
    stuck_d   = stuck_q;

    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      if (rise_q) begin
        cnt_d     = {{(CNT_W-1){1'b0}}, 1'b1};
        timeout_d = 1'b0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          // First rise only opens a measurement; the period before it is incomplete.
          if (rise_q) begin
            state_d = MEAS_HI;
          end else if (cnt_q == CNT_MAX && !timeout_q) begin
            timeout_d = 1'b1;
            stuck_d   = lvl_q;
          end
        end
        MEAS_HI: begin
          // A rise here means the fall was missed: restart without reporting.
          if (rise_q) begin
            state_d = MEAS_HI;
          end else if (fall_q) begin
            hi_lat_d = cnt_q;
            state_d  = MEAS_LO;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            stuck_d   = lvl_q;
            state_d   = IDLE;
          end
        end
        MEAS_LO: begin
          if (rise_q) begin
            period_d = cnt_q;
            high_d   = hi_lat_q;
            pend_d   = 1'b1;
            state_d  = MEAS_HI;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            stuck_d   = lvl_q;
            state_d   = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and result registers; valid follows the result update by one cycle.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_lat_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_lat_q  <= hi_lat_d;
      period_q  <= period_d;
      high_q    <= high_d;
      pend_q    <= pend_d;
      valid_q   <= pend_q & en;
      timeout_q <= timeout_d;
      stuck_q   <= stuck_d;
    end
  end

  assign period      = period_q;
  assign high_time   = high_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed PWM waveforms, expected results queued at each rise,
// a monitor pops and compares on every valid strobe (values and arrival cycle).
module tb_pwm_capture;

  localparam int CNT_W = 12;
  localparam int SYNC  = 2;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FLAT  = 3;
`else
  localparam int FLAT  = 0;
`endif
  // Edge at which the FSM acts on a rise driven at the preceding negedge (relative cycle).
  localparam int EVT   = SYNC + 2 + FLAT;
  localparam int MAXC  = 4095;

  logic             ck;
  logic             rst_n;
  logic             pwm_in;
  logic             en;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic             stuck_level;

  typedef struct {
    int per;
    int hi;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   t0;
  int   guard;

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .FILT_LEN(4)) dut (
    .ck          (ck),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .en          (en),
    .period      (period),
    .high_time   (high_time),
    .valid       (valid),
    .timeout     (timeout),
    .stuck_level (stuck_level)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  always @(posedge ck) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every valid must match the oldest queued expectation, including its cycle.
  always @(negedge ck) begin
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("period", int'(period), mon_e.per);
        check("high_time", int'(high_time), mon_e.hi);
        check("valid_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Called at a negedge: rise now, fall after hi cycles, return after lo more cycles.
  task automatic drive(input int hi, input int lo, input bit chk, input int ep, input int eh);
    pwm_in = 1'b1;
    if (chk) exp_q.push_back('{ep, eh, cyc + EVT + 1});
    repeat (hi) @(negedge ck);
    pwm_in = 1'b0;
    repeat (lo) @(negedge ck);
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge ck);
    check("rst_period", int'(period), 0);
    check("rst_high", int'(high_time), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_stuck", int'(stuck_level), 0);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (5) @(negedge ck);

    // 25/100 stream: first rise reports nothing.
    drive(25, 75, 1'b0, 0, 0);
    drive(25, 75, 1'b1, 100, 25);
    drive(25, 75, 1'b1, 100, 25);
    // Duty change to 75/100.
    drive(75, 25, 1'b1, 100, 25);
    drive(75, 25, 1'b1, 100, 75);

    // Rise, fall, then held low until timeout.
    pwm_in = 1'b1;
    exp_q.push_back('{100, 75, cyc + EVT + 1});
    t0 = cyc;
    repeat (30) @(negedge ck);
    pwm_in = 1'b0;
    repeat (t0 + EVT + MAXC - 1 - cyc) @(negedge ck);
    check("timeout_early", int'(timeout), 0);
    @(negedge ck);
    check("timeout_lo", int'(timeout), 1);
    check("stuck_lo", int'(stuck_level), 0);
    check("period_keep_lo", int'(period), 100);
    check("high_keep_lo", int'(high_time), 75);

    // Next rise clears timeout without a result; the one after reports.
    drive(20, 80, 1'b0, 0, 0);
    check("timeout_clear", int'(timeout), 0);
    drive(20, 80, 1'b1, 100, 20);

    // Held high until timeout.
    pwm_in = 1'b1;
    exp_q.push_back('{100, 20, cyc + EVT + 1});
    guard = 0;
    while (!timeout && guard < 5000) begin
      @(negedge ck);
      guard++;
    end
    check("timeout_hi", int'(timeout), 1);
    check("stuck_hi", int'(stuck_level), 1);
    check("period_keep_hi", int'(period), 100);
    check("high_keep_hi", int'(high_time), 20);
    pwm_in = 1'b0;
    repeat (10) @(negedge ck);
    drive(40, 60, 1'b0, 0, 0);

    // Reset pulse in the low phase.
    pwm_in = 1'b1;
    exp_q.push_back('{100, 40, cyc + EVT + 1});
    repeat (40) @(negedge ck);
    pwm_in = 1'b0;
    repeat (20) @(negedge ck);
    rst_n = 1'b0;
    #1;
    check("arst_period", int'(period), 0);
    check("arst_high", int'(high_time), 0);
    check("arst_valid", int'(valid), 0);
    check("arst_timeout", int'(timeout), 0);
    check("arst_stuck", int'(stuck_level), 0);
    @(negedge ck);
    rst_n = 1'b1;
    repeat (40) @(negedge ck);
    drive(30, 70, 1'b0, 0, 0);
    drive(30, 70, 1'b1, 100, 30);

    // en dropped mid-measurement: no result, values retained, restart from IDLE.
    pwm_in = 1'b1;
    exp_q.push_back('{100, 30, cyc + EVT + 1});
    repeat (10) @(negedge ck);
    en = 1'b0;
    repeat (3) @(negedge ck);
    en = 1'b1;
    repeat (27) @(negedge ck);
    pwm_in = 1'b0;
    repeat (60) @(negedge ck);
    check("en_keep_period", int'(period), 100);
    check("en_keep_high", int'(high_time), 30);
    drive(50, 50, 1'b0, 0, 0);
    drive(50, 50, 1'b1, 100, 50);

`ifdef PWM_CAPTURE_FILTER_EN
    // 2-cycle low glitch inside a 50-cycle high phase.
    pwm_in = 1'b1;
    exp_q.push_back('{100, 50, cyc + EVT + 1});
    repeat (20) @(negedge ck);
    pwm_in = 1'b0;
    repeat (2) @(negedge ck);
    pwm_in = 1'b1;
    repeat (28) @(negedge ck);
    pwm_in = 1'b0;
    repeat (50) @(negedge ck);
    drive(50, 50, 1'b1, 100, 50);
`endif

    repeat (20) @(negedge ck);
    check("pending_results", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
